// File: rtl/ttt_pkg.sv
// Shared encodings and sizes for the tic-tac-toe move sequencer.
package ttt_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned CELL_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    OVER    = 2'd3
  } state_t;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } player_t;

endpackage

// File: rtl/ttt_debounce.sv
// Single-bit debouncer: output follows the raw input only after DB_CYCLES
// consecutive identical samples that differ from the current debounced level.
module ttt_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (raw == db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
      cnt <= '0;
      db  <= raw;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Move sequencer for the tic-tac-toe core: debounce, select, handshake, turns.
// Define TTT_TIMEOUT_EN to enable the per-turn forfeit timer.
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = 4,
  parameter int unsigned TURN_TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CELLS-1:0] btn,
  input  logic [NUM_CELLS-1:0] occupied,
  input  logic                 game_over,
  input  logic                 move_ready,
  output logic                 move_valid,
  output logic [CELL_W-1:0]    move_cell,
  output logic                 move_player,
  output logic                 p1_turn,
  output logic                 p2_turn,
  output logic                 reject,
  output logic                 timeout_pulse
);

  if (DB_CYCLES < 2 || TURN_TIMEOUT < 2) begin : g_bad_cfg
    $error("ttt_move_ctrl: DB_CYCLES and TURN_TIMEOUT must be >= 2");
  end

  state_t               state;
  logic [NUM_CELLS-1:0] db;
  logic [NUM_CELLS-1:0] free_press;
  logic                 any_db;
  logic                 sel_found;
  logic [CELL_W-1:0]    sel_idx;

  for (genvar g = 0; g < int'(NUM_CELLS); g++) begin : g_db
    ttt_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (btn[g]),
      .db    (db[g])
    );
  end

  // Lowest-index pressed cell that is still free wins.
  always_comb begin
    any_db     = |db;
    free_press = db & ~occupied;
    sel_found  = 1'b0;
    sel_idx    = '0;
    for (int k = int'(NUM_CELLS) - 1; k >= 0; k--) begin
      if (free_press[k]) begin
        sel_found = 1'b1;
        sel_idx   = CELL_W'(k);
      end
    end
  end

`ifdef TTT_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TURN_TIMEOUT);
  logic [TMR_W-1:0] turn_timer;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      p1_turn     <= 1'b1;
      p2_turn     <= 1'b0;
      move_valid  <= 1'b0;
      move_cell   <= '0;
      move_player <= P1;
      reject      <= 1'b0;
`ifdef TTT_TIMEOUT_EN
      timeout_pulse <= 1'b0;
      turn_timer    <= '0;
`endif
    end else begin
      reject <= 1'b0;
`ifdef TTT_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (game_over) begin
            state <= OVER;
          end else if (sel_found) begin
            move_cell   <= sel_idx;
            move_player <= p2_turn ? P2 : P1;
            move_valid  <= 1'b1;
            state       <= ISSUE;
`ifdef TTT_TIMEOUT_EN
            turn_timer  <= '0;
`endif
          end else begin
            if (any_db) begin
              reject <= 1'b1;
              state  <= RELEASE;
            end
`ifdef TTT_TIMEOUT_EN
            if (turn_timer == TMR_W'(TURN_TIMEOUT - 1)) begin
              timeout_pulse <= 1'b1;
              p1_turn       <= ~p1_turn;
              p2_turn       <= ~p2_turn;
              turn_timer    <= '0;
            end else begin
              turn_timer <= turn_timer + TMR_W'(1);
            end
`endif
          end
        end
        // An accept in the same cycle as game_over still counts as a move.
        ISSUE: begin
          if (move_ready) begin
            move_valid <= 1'b0;
            p1_turn    <= ~p1_turn;
            p2_turn    <= ~p2_turn;
            state      <= game_over ? OVER : RELEASE;
`ifdef TTT_TIMEOUT_EN
            turn_timer <= '0;
`endif
          end else if (game_over) begin
            move_valid <= 1'b0;
            state      <= OVER;
          end
        end
        RELEASE: begin
          if (game_over) begin
            state <= OVER;
          end else if (!any_db) begin
            state <= IDLE;
          end
        end
        OVER: begin
          move_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef TTT_TIMEOUT_EN
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Directed table-driven bench for ttt_move_ctrl (DB_CYCLES=4, TURN_TIMEOUT=16).
module tb_ttt_move_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] btn = '0;
  logic [8:0] occupied = '0;
  logic       game_over = 1'b0;
  logic       move_ready = 1'b1;
  logic       move_valid;
  logic [3:0] move_cell;
  logic       move_player;
  logic       p1_turn;
  logic       p2_turn;
  logic       reject;
  logic       timeout_pulse;

  int n_vec = 0;
  int n_bad = 0;

  ttt_move_ctrl #(.DB_CYCLES(4), .TURN_TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .occupied      (occupied),
    .game_over     (game_over),
    .move_ready    (move_ready),
    .move_valid    (move_valid),
    .move_cell     (move_cell),
    .move_player   (move_player),
    .p1_turn       (p1_turn),
    .p2_turn       (p2_turn),
    .reject        (reject),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs applied before the edge, outputs expected after it.
  typedef struct {
    logic       rst;
    logic [8:0] btn;
    logic [8:0] occ;
    logic       rdy;
    logic       go;
    logic       ev;
    logic [3:0] ec;
    logic       ep;
    logic       ep1;
    logic       erj;
    logic       eto;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [8:0] b, input logic [8:0] o,
                     input logic rdy, input logic go, input logic ev,
                     input logic [3:0] ec, input logic ep, input logic ep1,
                     input logic erj, input logic eto, input int n);
    vec_t v;
    v.rst = rst; v.btn = b; v.occ = o; v.rdy = rdy; v.go = go;
    v.ev = ev; v.ec = ec; v.ep = ep; v.ep1 = ep1; v.erj = erj; v.eto = eto;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic ok;
    ok = (move_valid == v.ev) && (p1_turn == v.ep1) && (p2_turn == !v.ep1) &&
         (reject == v.erj) && (timeout_pulse == v.eto);
    if (v.ev) ok = ok && (move_cell == v.ec) && (move_player == v.ep);
    if (v.rst) ok = ok && (move_cell == 4'd0) && (move_player == 1'b0);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got valid=%b cell=%0d player=%b p1=%b p2=%b reject=%b timeout=%b; want valid=%b cell=%0d player=%b p1=%b reject=%b timeout=%b",
               idx, move_valid, move_cell, move_player, p1_turn, p2_turn, reject,
               timeout_pulse, v.ev, v.ec, v.ep, v.ep1, v.erj, v.eto);
    end
  endtask

  task automatic cmp(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; btn = '0; occupied = '0; game_over = 1'b0; move_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int moves;
    int first_cell;
    int first_edge;

    // Reset state, then idle: timer forfeits the turn only when enabled.
    add(1, 9'h000, 9'h000, 1, 0,  0, 0, 0,  1, 0, 0,  1);
`ifdef TTT_TIMEOUT_EN
    add(0, 9'h000, 9'h000, 1, 0,  0, 0, 0,  1, 0, 0, 15);
    add(0, 9'h000, 9'h000, 1, 0,  0, 0, 0,  0, 0, 1,  1);
    add(0, 9'h000, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  4);
    add(0, 9'h000, 9'h000, 1, 1,  0, 0, 0,  0, 0, 0,  1);
    add(0, 9'h001, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0, 10);
`else
    add(0, 9'h000, 9'h000, 1, 0,  0, 0, 0,  1, 0, 0, 20);
`endif

    // Held cell a: move at edge 5, accepted at edge 6, then release.
    add(1, 9'h000, 9'h000, 1, 0,  0, 0, 0,  1, 0, 0,  1);
    add(0, 9'h001, 9'h000, 1, 0,  0, 0, 0,  1, 0, 0,  4);
    add(0, 9'h001, 9'h000, 1, 0,  1, 0, 0,  1, 0, 0,  1);
    add(0, 9'h001, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  1);
    add(0, 9'h000, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  5);
    // Three-cycle glitch on cell e.
    add(0, 9'h010, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  3);
    add(0, 9'h000, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  4);
    // Cells c and f with c occupied: P2 takes f, held buttons give no second move.
    add(0, 9'h024, 9'h004, 1, 0,  0, 0, 0,  0, 0, 0,  4);
    add(0, 9'h024, 9'h004, 1, 0,  1, 5, 1,  0, 0, 0,  1);
    add(0, 9'h024, 9'h004, 1, 0,  0, 0, 0,  1, 0, 0,  5);
    add(0, 9'h000, 9'h004, 1, 0,  0, 0, 0,  1, 0, 0,  5);
    // Press on occupied cell a: one reject pulse, no turn change.
    add(0, 9'h001, 9'h001, 1, 0,  0, 0, 0,  1, 0, 0,  4);
    add(0, 9'h001, 9'h001, 1, 0,  0, 0, 0,  1, 1, 0,  1);
    add(0, 9'h001, 9'h001, 1, 0,  0, 0, 0,  1, 0, 0,  1);
    add(0, 9'h000, 9'h001, 1, 0,  0, 0, 0,  1, 0, 0,  5);
    // Core stalls five cycles: cell i held stable, single accept.
    add(0, 9'h100, 9'h000, 0, 0,  0, 0, 0,  1, 0, 0,  4);
    add(0, 9'h100, 9'h000, 0, 0,  1, 8, 0,  1, 0, 0,  6);
    add(0, 9'h100, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  1);
    add(0, 9'h000, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  5);
    // game_over while offering without ready: withdraw, no toggle, then frozen.
    add(0, 9'h008, 9'h000, 0, 0,  0, 0, 0,  0, 0, 0,  4);
    add(0, 9'h008, 9'h000, 0, 0,  1, 3, 1,  0, 0, 0,  1);
    add(0, 9'h008, 9'h000, 0, 1,  0, 0, 0,  0, 0, 0,  1);
    add(0, 9'h000, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  5);
    add(0, 9'h010, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  8);
    add(0, 9'h001, 9'h001, 1, 0,  0, 0, 0,  0, 0, 0,  8);
    // game_over together with ready: accept and toggle, then frozen.
    add(1, 9'h000, 9'h000, 1, 0,  0, 0, 0,  1, 0, 0,  1);
    add(0, 9'h001, 9'h000, 0, 0,  0, 0, 0,  1, 0, 0,  4);
    add(0, 9'h001, 9'h000, 0, 0,  1, 0, 0,  1, 0, 0,  1);
    add(0, 9'h001, 9'h000, 1, 1,  0, 0, 0,  0, 0, 0,  1);
    add(0, 9'h002, 9'h000, 1, 0,  0, 0, 0,  0, 0, 0,  8);
    // game_over in IDLE.
    add(1, 9'h000, 9'h000, 1, 0,  0, 0, 0,  1, 0, 0,  1);
    add(0, 9'h000, 9'h000, 1, 1,  0, 0, 0,  1, 0, 0,  1);
    add(0, 9'h002, 9'h000, 1, 0,  0, 0, 0,  1, 0, 0,  8);

    foreach (vq[i]) begin
      btn        = vq[i].btn;
      occupied   = vq[i].occ;
      move_ready = vq[i].rdy;
      game_over  = vq[i].go;
      if (vq[i].rst) reset = 1'b1;
      @(posedge clk); #1;
      check_vec(i, vq[i]);
      reset = 1'b0;
    end

    // All nine buttons at once: exactly one move, for cell a, at edge 5.
    do_reset();
    btn = 9'h1FF;
    moves = 0; first_cell = -1; first_edge = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (move_valid) begin
        moves++;
        if (first_edge < 0) begin
          first_edge = c;
          first_cell = int'(move_cell);
        end
      end
    end
    cmp("all_buttons_moves", moves, 1);
    cmp("all_buttons_cell", first_cell, 0);
    cmp("all_buttons_latency", first_edge, 5);

    // Asynchronous reset while a move is being offered.
    do_reset();
    btn = 9'h004; move_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    cmp("offer_before_reset_valid", int'(move_valid), 1);
    cmp("offer_before_reset_cell", int'(move_cell), 2);
    #2 reset = 1'b1;
    #1;
    cmp("async_reset_valid", int'(move_valid), 0);
    cmp("async_reset_cell", int'(move_cell), 0);
    cmp("async_reset_p1", int'(p1_turn), 1);
    @(negedge clk) reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ttt_move_ctrl.md
Name: ttt_move_ctrl

Overview:
Move sequencer in front of the tic_tac_toe game core. Takes the nine raw cell buttons (a..i packed into btn[8:0]) and debounces them. Resolves simultaneous presses and rejects presses on occupied cells. Issues exactly one move per press to the core over a valid/ready handshake, and owns the turn flags and an optional per-turn timeout.

Parameters:
DB_CYCLES, 4, consecutive identical raw samples required to change a debounced button state (>=2).
TURN_TIMEOUT, 1000, idle cycles before the current player's turn is forfeited (>=2).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
btn  in  9  raw cell buttons; bit0=a … bit8=i.
occupied  in  9  cell-taken flags from the core, same bit order.
game_over  in  1  core win or grid_full indication, level.
move_ready  in  1  core accepts a move this cycle.
move_valid  out  1  move offered to the core.
move_cell  out  4  cell index 0..8.
move_player  out  1  0=P1, 1=P2.
p1_turn  out  1  P1 to move.
p2_turn  out  1  P2 to move.
reject  out  1  one-cycle pulse: press on an occupied cell.
timeout_pulse  out  1  one-cycle pulse: turn forfeited.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; p1_turn=1, p2_turn=0; move_valid=0, move_cell=0, move_player=0; reject=0, timeout_pulse=0; debounce counters and debounced bits 0; turn timer 0.
- Debounce, per bit:
  - db[k] sets after DB_CYCLES consecutive rising edges sampling btn[k]=1.
  - db[k] clears after DB_CYCLES consecutive edges sampling 0.
  - Any disagreeing sample restarts the count.
- States: IDLE, ISSUE, RELEASE, OVER.
- IDLE:
  - If any db bit is set, select the lowest index k with db[k]=1 and occupied[k]=0. Register move_cell=k and move_player=p2_turn, assert move_valid, go to ISSUE.
  - If db bits are set but all are occupied: pulse reject for 1 cycle, go to RELEASE.
- Latency: move_valid rises on the edge after the edge that set db[k]. With btn held from edge 1, db is set at edge DB_CYCLES and move_valid at edge DB_CYCLES+1.
- ISSUE:
  - move_valid, move_cell and move_player stay stable until a cycle with move_ready=1.
  - On that edge: deassert move_valid, toggle p1_turn/p2_turn, clear the turn timer, go to RELEASE.
  - move_ready while move_valid=0 is ignored.
- RELEASE: wait until db==0, then go to IDLE. Held or extra buttons never produce a second move.
- game_over=1 in IDLE or RELEASE: go to OVER next edge.
- game_over=1 in ISSUE: drop move_valid next edge, no turn toggle, go to OVER. move_ready in the same cycle as game_over is still honoured as an accept (toggle), then go to OVER.
- OVER: move_valid=0, turn flags frozen, buttons ignored. Exit only via reset.
- p1_turn and p2_turn are always complementary outside reset.

Optional Feature:
TTT_TIMEOUT_EN
- Defined: the turn timer increments every cycle in IDLE only and holds in the other states. When it reaches TURN_TIMEOUT-1 in IDLE: pulse timeout_pulse, toggle the turn flags, clear the timer.
- A press selected in the same cycle as the timeout has priority; the timeout is discarded and the timer cleared.
- Undefined: no timer logic; timeout_pulse tied 0.

Decomposition:
- Package ttt_pkg holds:
  - state encoding: IDLE=0, ISSUE=1, RELEASE=2, OVER=3;
  - player encoding: P1=0, P2=1;
  - NUM_CELLS=9, CELL_W=4.
- Natural sub-module: ttt_debounce, one bit with DB_CYCLES parameter, instantiated 9x via generate.

Test Plan (DB_CYCLES=4, TURN_TIMEOUT=16, move_ready tied 1 unless stated):
- Reset, then hold btn=9'b000000001 for 6 cycles → move_valid high exactly 1 cycle at edge 5, move_cell=0, move_player=0; then p2_turn=1.
- btn[4] glitch high for 3 cycles, then low → no move_valid, no reject.
- btn=9'b000100100 (cells 2, 5) with occupied=9'b000000100 → move_cell=5; exactly one move; release required before the next move.
- btn[0] pressed with occupied[0]=1 → reject pulses once, move_valid stays 0, turn unchanged.
- move_ready=0 for 5 cycles after move_valid → move_cell/move_player stable; on move_ready=1, one accept and one toggle.
- TTT_TIMEOUT_EN defined, no presses → timeout_pulse at cycle 16 after entering IDLE, p1_turn→0; assert game_over → OVER, later presses ignored until reset.
